// File: rtl/median_task_sender_pkg.sv
// Shared median package: FSM state encoding, default token constants and
// the per-window control-token bookkeeping type.
package median_task_sender_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CTRL = 2'd1,
    ST_PX   = 2'd2
  } state_e;

  localparam logic [7:0] MEDIAN_DEFAULT_PIVOT  = 8'd127;
  localparam logic [7:0] SECOND_MEDIAN_DEFAULT = 8'd0;

  // One completion flag per control token of the current window.
  typedef struct packed {
    logic pivot;
    logic buff_size;
    logic median_pos;
    logic second_median;
  } tok_flags_t;

endpackage

// File: rtl/median_task_sender_pivot_mean_acc.sv
// pivot_mean_acc: sums one window of pixels and presents the window mean,
// including the pixel being added this cycle, for the pivot register to load.
module pivot_mean_acc #(
  parameter int unsigned BUFF_SIZE = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] px,
  output logic [7:0] mean_c
);

  localparam int unsigned LOG2_SIZE = $clog2(BUFF_SIZE);
  localparam int unsigned ACC_W     = 8 + LOG2_SIZE;

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] sum_c;

  assign sum_c  = acc_q + ACC_W'(px);
  assign mean_c = 8'(sum_c >> LOG2_SIZE);

  always_comb begin
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (add_en) begin
      acc_d = sum_c;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/median_task_sender.sv
// Median task sender: per window, emits four control tokens then streams
// BUFF_SIZE pixels. Optional mean pivot under MEDIAN_TASK_SENDER_MEAN_PIVOT_EN.
module median_task_sender
  import median_task_sender_pkg::*;
#(
  parameter int unsigned BUFF_SIZE     = 1024,
  parameter int unsigned BUFF_SIZE_BIT = 16,
  parameter int unsigned MEDIAN_POS    = 512,
  parameter logic [7:0]  DEFAULT_PIVOT = MEDIAN_DEFAULT_PIVOT
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [7:0]               src_px,
  input  logic                     src_px_empty,
  output logic                     src_px_rd,
  output logic [7:0]               out_px,
  output logic                     out_px_wr,
  input  logic                     out_px_full,
  output logic [7:0]               out_pivot,
  output logic                     out_pivot_wr,
  input  logic                     out_pivot_full,
  output logic [BUFF_SIZE_BIT-1:0] out_buff_size,
  output logic                     out_buff_size_wr,
  input  logic                     out_buff_size_full,
  output logic [BUFF_SIZE_BIT-1:0] out_median_pos,
  output logic                     out_median_pos_wr,
  input  logic                     out_median_pos_full,
  output logic [7:0]               out_second_median_value,
  output logic                     out_second_median_value_wr,
  input  logic                     out_second_median_value_full,
  output logic                     busy
);

  state_e                   state_q, state_d;
  tok_flags_t               sent_q, sent_d;
  logic [BUFF_SIZE_BIT-1:0] cnt_q, cnt_d;
  logic [7:0]               pivot_q, pivot_d;
  logic                     xfer_c;
  logic                     last_c;

  assign xfer_c = (state_q == ST_PX) && !src_px_empty && !out_px_full;
  assign last_c = xfer_c && (cnt_q == BUFF_SIZE_BIT'(BUFF_SIZE - 1));
  assign busy   = (state_q != ST_IDLE);

  // Next state, token handshakes and the zero-latency pixel pass-through.
  always_comb begin
    state_d                    = state_q;
    sent_d                     = sent_q;
    cnt_d                      = cnt_q;
    src_px_rd                  = 1'b0;
    out_px                     = 8'd0;
    out_px_wr                  = 1'b0;
    out_pivot                  = 8'd0;
    out_pivot_wr               = 1'b0;
    out_buff_size              = '0;
    out_buff_size_wr           = 1'b0;
    out_median_pos             = '0;
    out_median_pos_wr          = 1'b0;
    out_second_median_value    = 8'd0;
    out_second_median_value_wr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!src_px_empty) begin
          state_d = ST_CTRL;
        end
      end
      ST_CTRL: begin
        out_pivot               = pivot_q;
        out_buff_size           = BUFF_SIZE_BIT'(BUFF_SIZE);
        out_median_pos          = BUFF_SIZE_BIT'(MEDIAN_POS);
        out_second_median_value = SECOND_MEDIAN_DEFAULT;
        if (&sent_q) begin
          state_d = ST_PX;
          sent_d  = '0;
        end else begin
          // Each token goes out on its own first non-full cycle.
          if (!sent_q.pivot && !out_pivot_full) begin
            out_pivot_wr = 1'b1;
            sent_d.pivot = 1'b1;
          end
          if (!sent_q.buff_size && !out_buff_size_full) begin
            out_buff_size_wr = 1'b1;
            sent_d.buff_size = 1'b1;
          end
          if (!sent_q.median_pos && !out_median_pos_full) begin
            out_median_pos_wr = 1'b1;
            sent_d.median_pos = 1'b1;
          end
          if (!sent_q.second_median && !out_second_median_value_full) begin
            out_second_median_value_wr = 1'b1;
            sent_d.second_median       = 1'b1;
          end
        end
      end
      ST_PX: begin
        out_px = src_px;
        if (xfer_c) begin
          src_px_rd = 1'b1;
          out_px_wr = 1'b1;
          if (last_c) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + BUFF_SIZE_BIT'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef MEDIAN_TASK_SENDER_MEAN_PIVOT_EN
  logic [7:0] mean_c;
  logic       acc_clear_c;

  // Accumulator restarts when a new window is accepted.
  assign acc_clear_c = (state_q == ST_IDLE) && !src_px_empty;

  pivot_mean_acc #(
    .BUFF_SIZE(BUFF_SIZE)
  ) u_pivot_mean_acc (
    .clock (clock),
    .reset (reset),
    .clear (acc_clear_c),
    .add_en(xfer_c),
    .px    (src_px),
    .mean_c(mean_c)
  );

  always_comb begin
    pivot_d = pivot_q;
    if (last_c) begin
      pivot_d = mean_c;
    end
  end
`else
  always_comb begin
    pivot_d = pivot_q;
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      sent_q  <= '0;
      cnt_q   <= '0;
      pivot_q <= DEFAULT_PIVOT;
    end else begin
      state_q <= state_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
      pivot_q <= pivot_d;
    end
  end

endmodule

// File: doc/median_task_sender.md
MEDIAN_TASK_SENDER -- requirements
Module: median_task_sender

Interface
REQ-001 SHALL have parameter BUFF_SIZE, default 1024, pixels per window (power of two, >=2).
REQ-002 SHALL have parameter BUFF_SIZE_BIT, default 16, width of size/position tokens.
REQ-003 SHALL have parameter MEDIAN_POS, default 512, initial median position token.
REQ-004 SHALL have parameter DEFAULT_PIVOT, default 8'd127, initial pivot token.
REQ-005 clock  in  1  system clock, rising edge.
REQ-006 reset  in  1  reset, asynchronous, active-low.
REQ-007 src_px  in  8  upstream pixel, valid while src_px_empty=0 (first-word-fall-through FIFO).
REQ-008 src_px_empty  in  1  upstream FIFO empty.
REQ-009 src_px_rd  out  1  upstream FIFO read strobe.
REQ-010 out_px  out  8  pixel token to stage FIFO.
REQ-011 out_px_wr / out_px_full  out/in  1/1  pixel FIFO write strobe / full.
REQ-012 out_pivot  out  8, plus out_pivot_wr out 1, out_pivot_full in 1.
REQ-013 out_buff_size  out  BUFF_SIZE_BIT, plus out_buff_size_wr out 1, out_buff_size_full in 1.
REQ-014 out_median_pos  out  BUFF_SIZE_BIT, plus out_median_pos_wr out 1, out_median_pos_full in 1.
REQ-015 out_second_median_value  out  8, plus out_second_median_value_wr out 1, out_second_median_value_full in 1.
REQ-016 busy  out  1  high whenever state is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, CTRL, PX.
REQ-018 IDLE -> CTRL when src_px_empty=0; otherwise stays in IDLE.
REQ-019 In CTRL, each of the four control tokens SHALL be written exactly once, independently, in the first cycle its FIFO is not full; a per-token sent flag records completion.
REQ-020 Control token values: pivot=current pivot register, buff_size=BUFF_SIZE, median_pos=MEDIAN_POS, second_median_value=8'd0.
REQ-021 CTRL -> PX in the cycle after all four sent flags are set; the flags clear on that transition.
REQ-022 In PX: src_px_rd = out_px_wr = (~src_px_empty & ~out_px_full); out_px = src_px combinationally; zero added latency.
REQ-023 Pixel counter (BUFF_SIZE_BIT wide) increments per transfer; on the transfer with count=BUFF_SIZE-1 the counter clears to 0 and the FSM goes to IDLE.
REQ-024 Empty or full in PX stalls with no strobe and no count change; stalls of any length are legal.
REQ-025 src_px_rd SHALL never assert outside PX; no *_wr SHALL assert while its *_full is high.
REQ-026 A src_px value present in IDLE SHALL NOT be consumed before the window's control tokens are sent.

Reset
REQ-027 On reset low: state=IDLE; all *_wr and src_px_rd=0; counter=0; sent flags=0; pivot register=DEFAULT_PIVOT; busy=0; data outputs=0.
REQ-028 Reset mid-window SHALL abandon the window; after release the next window starts with fresh control tokens.

Configuration
REQ-029 Macro MEDIAN_TASK_SENDER_MEAN_PIVOT_EN: when defined, an accumulator (8+log2(BUFF_SIZE) bits) sums the window's pixels and, on window completion, the pivot register loads sum>>log2(BUFF_SIZE); the accumulator clears at the start of each window.
REQ-030 When undefined, the pivot register SHALL hold DEFAULT_PIVOT permanently and no accumulator SHALL exist.

Structure
REQ-031 The shared median package SHALL hold the FSM state encoding and the default token constants (DEFAULT_PIVOT, second-median default 0).
REQ-032 The optional mean accumulator SHALL be a sub-module named pivot_mean_acc; all other logic SHALL be flat.

Verification
REQ-033 BUFF_SIZE=4; src FIFO holds 10,20,30,40 with no full -> tokens 127/4/MEDIAN_POS/0 written once each, then out_px sequence 10,20,30,40; busy falls after the 4th pixel.
REQ-034 out_buff_size_full held high 5 cycles in CTRL -> the other three tokens are written immediately, buff_size on the first non-full cycle, and no pixel is read before it.
REQ-035 out_px_full toggled every other cycle mid-window -> no pixel is lost or duplicated, and the count reaches exactly BUFF_SIZE.
REQ-036 Reset asserted after 2 of 4 pixels -> all strobes drop asynchronously; after release the next window re-emits its control tokens.
REQ-037 With MEDIAN_TASK_SENDER_MEAN_PIVOT_EN defined: window 1 = 8,8,16,16 -> window 2 pivot token=12; without the macro, window 2 pivot=127.
